// File: rtl/music_pkg.sv
// Shared definitions for the melody player: note codes, ROM entry layout,
// the melody contents and the sequencer state encoding.
package music_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C3   = 4'd1;
    localparam logic [3:0] NOTE_CS3  = 4'd2;
    localparam logic [3:0] NOTE_D3   = 4'd3;
    localparam logic [3:0] NOTE_DS3  = 4'd4;
    localparam logic [3:0] NOTE_E3   = 4'd5;
    localparam logic [3:0] NOTE_F3   = 4'd6;
    localparam logic [3:0] NOTE_FS3  = 4'd7;
    localparam logic [3:0] NOTE_G3   = 4'd8;
    localparam logic [3:0] NOTE_GS3  = 4'd9;
    localparam logic [3:0] NOTE_A3   = 4'd10;
    localparam logic [3:0] NOTE_AS3  = 4'd11;
    localparam logic [3:0] NOTE_B3   = 4'd12;

    typedef struct packed {
        logic [3:0] note;
        logic [2:0] dur;
    } rom_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // dur is in beats; a dur of 0 plays as a single beat.
    function automatic rom_entry_t song_rom(input logic [3:0] idx);
        rom_entry_t e;
        case (idx)
            4'd0:  e = '{note: NOTE_D3,   dur: 3'd1};
            4'd1:  e = '{note: NOTE_REST, dur: 3'd2};
            4'd2:  e = '{note: NOTE_E3,   dur: 3'd0};
            4'd3:  e = '{note: NOTE_C3,   dur: 3'd1};
            4'd4:  e = '{note: NOTE_G3,   dur: 3'd2};
            4'd5:  e = '{note: NOTE_A3,   dur: 3'd1};
            4'd6:  e = '{note: NOTE_G3,   dur: 3'd1};
            4'd7:  e = '{note: NOTE_F3,   dur: 3'd2};
            4'd8:  e = '{note: NOTE_E3,   dur: 3'd1};
            4'd9:  e = '{note: NOTE_D3,   dur: 3'd1};
            4'd10: e = '{note: NOTE_C3,   dur: 3'd2};
            4'd11: e = '{note: NOTE_REST, dur: 3'd1};
            4'd12: e = '{note: NOTE_G3,   dur: 3'd1};
            4'd13: e = '{note: NOTE_E3,   dur: 3'd1};
            4'd14: e = '{note: NOTE_D3,   dur: 3'd2};
            default: e = '{note: NOTE_C3, dur: 3'd3};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Play-button conditioner: two-flop synchronizer, stability down-counter and
// a single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int TICK_CYC = 20000,
    parameter int DEB_MS   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int DEB_CYC = DEB_MS * TICK_CYC;
    localparam int CNT_W   = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement reloads it, so bounces restart the wait.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = CNT_LOAD;
        if (sync2_q != level_q) begin
            if (cnt_q == '0) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/melody_sequencer.sv
// Melody player: walks the song ROM, holding each note then a short silent gap.
//   state   | meaning
//   IDLE    | stopped, outputs silent, waiting for a press
//   NOTE    | current step's note sounding (gate off for rests)
//   GAP     | silent tail of the step, then advance / loop / stop
module melody_sequencer
    import music_pkg::*;
#(
    parameter int TICK_CYC = 20000,
    parameter int BEAT_MS  = 250,
    parameter int GAP_MS   = 20,
    parameter int DEB_MS   = 10,
    parameter int SONG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_btn,
    input  logic       loop,
    output logic [3:0] note_sel,
    output logic       note_en,
    output logic       busy,
    output logic [3:0] step_idx
);

    localparam int PRE_W = $clog2(TICK_CYC + 1);
    localparam int MS_W  = $clog2(7 * BEAT_MS + 1);
    localparam logic [PRE_W-1:0] PRE_LOAD  = PRE_W'(TICK_CYC - 1);
    localparam logic [MS_W-1:0]  GAP_LOAD  = MS_W'(GAP_MS - 1);
    localparam logic [3:0]       LAST_STEP = 4'(SONG_LEN - 1);

    function automatic logic [MS_W-1:0] note_load(input logic [2:0] dur);
        int beats;
        beats = (dur == 3'd0) ? 1 : int'(dur);
        return MS_W'(beats * BEAT_MS - GAP_MS - 1);
    endfunction

    logic             play_pulse;
    state_t           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [3:0]       note_sel_q, note_sel_d;
    logic             note_en_q, note_en_d;
    logic             busy_q, busy_d;
    logic             timer_done;
    rom_entry_t       next_entry;

    btn_debounce #(
        .TICK_CYC (TICK_CYC),
        .DEB_MS   (DEB_MS)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (play_btn),
        .btn_pulse (play_pulse)
    );

    assign timer_done = (pre_q == '0) && (ms_q == '0);
    assign next_entry = song_rom(step_d);

    // A press while playing always stops, even on the cycle a gap ends.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (play_pulse) begin
                    state_d = ST_NOTE;
                    step_d  = 4'd0;
                end
            end
            ST_NOTE: begin
                if (play_pulse) begin
                    state_d = ST_IDLE;
                    step_d  = 4'd0;
                end else if (timer_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (play_pulse) begin
                    state_d = ST_IDLE;
                    step_d  = 4'd0;
                end else if (timer_done) begin
                    if (step_q != LAST_STEP) begin
                        state_d = ST_NOTE;
                        step_d  = step_q + 4'd1;
                    end else if (loop) begin
                        state_d = ST_NOTE;
                        step_d  = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                        step_d  = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 4'd0;
            end
        endcase
    end

    // Every state change is also a step boundary, so reloading on any change
    // keeps each duration exact.
    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if (state_d != state_q) begin
            pre_d = PRE_LOAD;
            case (state_d)
                ST_NOTE: ms_d = note_load(next_entry.dur);
                ST_GAP:  ms_d = GAP_LOAD;
                default: ms_d = '0;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (pre_q == '0) begin
                pre_d = PRE_LOAD;
                if (ms_q != '0) begin
                    ms_d = ms_q - 1'b1;
                end
            end else begin
                pre_d = pre_q - 1'b1;
            end
        end
    end

    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        note_sel_d = (state_d == ST_IDLE) ? NOTE_REST : next_entry.note;
        note_en_d  = (state_d == ST_NOTE) && (next_entry.note != NOTE_REST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= 4'd0;
            pre_q      <= PRE_LOAD;
            ms_q       <= '0;
            note_sel_q <= NOTE_REST;
            note_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            pre_q      <= pre_d;
            ms_q       <= ms_d;
            note_sel_q <= note_sel_d;
            note_en_q  <= note_en_d;
            busy_q     <= busy_d;
        end
    end

    assign note_sel = note_sel_q;
    assign note_en  = note_en_q;
    assign busy     = busy_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with a four-step song and short timings.
module tb_melody_sequencer;

    localparam int TICK = 4;
    localparam int BEAT = 5;
    localparam int GAP  = 1;
    localparam int DEB  = 2;
    localparam int LEN  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play_btn = 1'b0;
    logic       loop = 1'b0;
    logic [3:0] note_sel;
    logic       note_en;
    logic       busy;
    logic [3:0] step_idx;

    int n_vec     = 0;
    int n_miss    = 0;
    int pulse_cnt = 0;
    int btn_hold  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    melody_sequencer #(
        .TICK_CYC (TICK),
        .BEAT_MS  (BEAT),
        .GAP_MS   (GAP),
        .DEB_MS   (DEB),
        .SONG_LEN (LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play_btn (play_btn),
        .loop     (loop),
        .note_sel (note_sel),
        .note_en  (note_en),
        .busy     (busy),
        .step_idx (step_idx)
    );

    // Independent copy of the first four melody steps.
    function automatic logic [3:0] mel_note(input int s);
        case (s)
            0: return 4'd3;
            1: return 4'd0;
            2: return 4'd5;
            default: return 4'd1;
        endcase
    endfunction

    function automatic int mel_dur(input int s);
        case (s)
            0: return 1;
            1: return 2;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] pack(input logic [3:0] sel, input logic en,
                                         input logic bsy, input logic [3:0] idx);
        return {6'd0, sel, en, bsy, idx};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (dut.play_pulse) pulse_cnt++;
        if (btn_hold > 0) begin
            btn_hold--;
            if (btn_hold == 0) play_btn = 1'b0;
        end
    endtask

    task automatic press(input int hold);
        play_btn = 1'b1;
        btn_hold = hold;
    endtask

    task automatic wait_pulse();
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            lat++;
            if (dut.play_pulse) seen = 1'b1;
        end
        check("deb_latency", 16'(lat), 16'(2 + DEB * TICK));
    endtask

    task automatic push_melody();
        for (int s = 0; s < LEN; s++) begin
            int beats;
            beats = (mel_dur(s) == 0) ? 1 : mel_dur(s);
            for (int c = 0; c < (beats * BEAT - GAP) * TICK; c++)
                exp_q.push_back(pack(mel_note(s), mel_note(s) != 4'd0, 1'b1, 4'(s)));
            for (int c = 0; c < GAP * TICK; c++)
                exp_q.push_back(pack(mel_note(s), 1'b0, 1'b1, 4'(s)));
        end
    endtask

    task automatic drain(input string tag);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check(tag, pack(note_sel, note_en, busy, step_idx), e);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_note_sel", 16'(note_sel), 16'd0);
        check("rst_note_en",  16'(note_en),  16'd0);
        check("rst_busy",     16'(busy),     16'd0);
        check("rst_step_idx", 16'(step_idx), 16'd0);

        press(5);
        repeat (25) tick();
        check("glitch_pulses", 16'(pulse_cnt), 16'd0);
        check("glitch_busy",   16'(busy),      16'd0);

        loop = 1'b0;
        press(12);
        wait_pulse();
        push_melody();
        repeat (3) exp_q.push_back(pack(4'd0, 1'b0, 1'b0, 4'd0));
        drain("play_once");
        check("one_pulse", 16'(pulse_cnt), 16'd1);

        loop = 1'b1;
        press(12);
        wait_pulse();
        push_melody();
        repeat (2) exp_q.push_back(pack(4'd3, 1'b1, 1'b1, 4'd0));
        drain("play_loop");

        press(12);
        wait_pulse();
        check("stop_pre_en", 16'(note_en), 16'd1);
        tick();
        check("stop_outputs", pack(note_sel, note_en, busy, step_idx), pack(4'd0, 1'b0, 1'b0, 4'd0));
        check("stop_state",   16'(dut.state_q), 16'd0);
        check("stop_pulses",  16'(pulse_cnt), 16'd3);
        repeat (20) tick();

        loop = 1'b0;
        press(12);
        wait_pulse();
        repeat (5) tick();
        check("rst_pre_en", 16'(note_en), 16'd1);
        rst = 1'b1;
        tick();
        check("midrst_outputs", pack(note_sel, note_en, busy, step_idx), pack(4'd0, 1'b0, 1'b0, 4'd0));
        rst = 1'b0;
        repeat (15) tick();
        check("post_rst_busy", 16'(busy), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
